// File: rtl/gray2bin_sync.sv
// Synchronises a Gray-coded pointer from another clock domain, converts it to binary and
// reports changes, step size and illegal multi-bit steps (checker built only with GRAY_STEP_CHK_EN).
module gray2bin_sync #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int ERR_CNT_W   = 4
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic [WIDTH-1:0]     addr_gray,
    input  logic                 err_clr,
    output logic [WIDTH-1:0]     addr,
    output logic                 addr_vld,
    output logic [WIDTH-1:0]     delta,
    output logic                 step_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int                FILL_W    = $clog2(SYNC_STAGES + 2);
    localparam logic [FILL_W-1:0] FILL_DONE = FILL_W'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  s_last;
    logic [WIDTH-1:0]                  prev_gray_q;
    logic [WIDTH-1:0]                  addr_q, addr_d;
    logic [WIDTH-1:0]                  delta_q, delta_d;
    logic                              addr_vld_q, addr_vld_d;
    logic [FILL_W-1:0]                 fill_q, fill_d;
    logic                              primed;
    logic                              changed;

    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b            = '0;
        b[WIDTH-1]   = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Plain flop chain: index 0 takes the raw asynchronous input, nothing sits between stages.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], addr_gray};
        end
    end

    assign s_last = sync_q[SYNC_STAGES-1];

    // Until the chain has flushed a real sample into addr, change reporting is suppressed.
    always_comb begin
        primed     = (fill_q == FILL_DONE);
        fill_d     = primed ? fill_q : fill_q + 1'b1;
        changed    = (s_last != prev_gray_q);
        addr_d     = gray2bin(s_last);
        addr_vld_d = primed && changed;
        delta_d    = addr_vld_d ? (addr_d - addr_q) : '0;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            fill_q      <= '0;
            prev_gray_q <= '0;
            addr_q      <= '0;
            addr_vld_q  <= 1'b0;
            delta_q     <= '0;
        end else begin
            fill_q      <= fill_d;
            prev_gray_q <= s_last;
            addr_q      <= addr_d;
            addr_vld_q  <= addr_vld_d;
            delta_q     <= delta_d;
        end
    end

    assign addr     = addr_q;
    assign addr_vld = addr_vld_q;
    assign delta    = delta_q;

`ifdef GRAY_STEP_CHK_EN
    logic [WIDTH-1:0]     step_diff;
    logic                 multi_bit;
    logic                 step_err_q, step_err_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    // More than one bit set iff clearing the lowest set bit leaves something behind.
    always_comb begin
        step_diff  = s_last ^ prev_gray_q;
        multi_bit  = ((step_diff & (step_diff - 1'b1)) != '0);
        step_err_d = primed && multi_bit;
        err_cnt_d  = err_cnt_q;
        if (err_clr) begin
            err_cnt_d = ERR_CNT_W'(step_err_d);
        end else if (step_err_d && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            step_err_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            step_err_q <= step_err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign step_err = step_err_q;
    assign err_cnt  = err_cnt_q;
`else
    logic unused_err_clr;

    assign unused_err_clr = err_clr;
    assign step_err       = 1'b0;
    assign err_cnt        = '0;
`endif

endmodule

// File: tb/tb_gray2bin_sync.sv
// Scoreboard bench for gray2bin_sync: directed Gray vectors with hand-computed expectations,
// checked by an independent monitor whenever addr_vld pulses.
module tb_gray2bin_sync;

    localparam int WIDTH       = 8;
    localparam int SYNC_STAGES = 2;
    localparam int ERR_CNT_W   = 4;
`ifdef GRAY_STEP_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic                 sys_clk;
    logic                 sys_rst_n;
    logic [WIDTH-1:0]     addr_gray;
    logic                 err_clr;
    logic [WIDTH-1:0]     addr;
    logic                 addr_vld;
    logic [WIDTH-1:0]     delta;
    logic                 step_err;
    logic [ERR_CNT_W-1:0] err_cnt;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] delta;
        logic       stepErr;
        logic [3:0] errCnt;
    } expT;

    expT        sbQ[$];
    expT        monRec;
    int         testsRun  = 0;
    int         failCount = 0;
    bit         monEn     = 1'b0;
    bit [1:0]   clrPipe   = 2'b00;
    logic [7:0] lastGray  = 8'h00;
    logic [3:0] expErrCnt = 4'd0;

    gray2bin_sync #(
        .WIDTH      (WIDTH),
        .SYNC_STAGES(SYNC_STAGES),
        .ERR_CNT_W  (ERR_CNT_W)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .addr_gray(addr_gray),
        .err_clr  (err_clr),
        .addr     (addr),
        .addr_vld (addr_vld),
        .delta    (delta),
        .step_err (step_err),
        .err_cnt  (err_cnt)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: actual 0x%0h, required 0x%0h", name, actual, expected);
        end
    endtask

    // err_clr is delayed two calls so it lands on the edge that evaluates this call's sample.
    task automatic applyStimulus(input logic [7:0] gray, input bit clr, input bit chg,
                                 input logic [7:0] expAddr, input logic [7:0] expDelta,
                                 input bit expStep);
        expT e;
        bit  s;
        @(negedge sys_clk);
        addr_gray = gray;
        err_clr   = clrPipe[1];
        clrPipe   = {clrPipe[0], clr};
        lastGray  = gray;
        s         = expStep && CHK;
        if (clr && CHK) begin
            expErrCnt = s ? 4'd1 : 4'd0;
        end else if (s && (expErrCnt != 4'hF)) begin
            expErrCnt = expErrCnt + 4'd1;
        end
        if (chg) begin
            e.addr    = expAddr;
            e.delta   = expDelta;
            e.stepErr = s;
            e.errCnt  = expErrCnt;
            sbQ.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(lastGray, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        end
    endtask

    // Monitor: every addr_vld pulse must match the oldest outstanding expectation.
    always @(negedge sys_clk) begin
        if (monEn) begin
            if (addr_vld === 1'b1) begin
                if (sbQ.size() == 0) begin
                    testsRun++;
                    failCount++;
                    $display("[TB] FAIL unexpected_vld: actual addr 0x%0h delta 0x%0h, required no pulse", addr, delta);
                end else begin
                    monRec = sbQ.pop_front();
                    checkOutput("vld_addr",    32'(addr),     32'(monRec.addr));
                    checkOutput("vld_delta",   32'(delta),    32'(monRec.delta));
                    checkOutput("vld_steperr", 32'(step_err), 32'(monRec.stepErr));
                    checkOutput("vld_errcnt",  32'(err_cnt),  32'(monRec.errCnt));
                end
            end else begin
                checkOutput("idle_delta_step", 32'({step_err, delta}), 32'h0);
            end
        end
    end

    initial begin
        logic [7:0] grayTab [9];
        grayTab   = '{8'h01, 8'h03, 8'h02, 8'h06, 8'h07, 8'h05, 8'h04, 8'h0C, 8'h0D};
        sys_rst_n = 1'b0;
        addr_gray = 8'h0C;
        err_clr   = 1'b0;
        lastGray  = 8'h0C;

        // Reset state, then priming with a stable input of 0x0C.
        @(negedge sys_clk);
        monEn = 1'b1;
        repeat (2) @(negedge sys_clk);
        checkOutput("rst_addr",    32'(addr),     32'h0);
        checkOutput("rst_vld",     32'(addr_vld), 32'h0);
        checkOutput("rst_delta",   32'(delta),    32'h0);
        checkOutput("rst_steperr", 32'(step_err), 32'h0);
        checkOutput("rst_errcnt",  32'(err_cnt),  32'h0);
        sys_rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge sys_clk);
            checkOutput("prime_addr", 32'(addr), (i == 2) ? 32'h08 : 32'h00);
        end
        idle(2);

        // Step down to zero with single-bit changes, then count 0..9.
        applyStimulus(8'h04, 1'b0, 1'b1, 8'h07, 8'hFF, 1'b0);
        applyStimulus(8'h00, 1'b0, 1'b1, 8'h00, 8'hF9, 1'b0);
        for (int i = 0; i < 9; i++) begin
            applyStimulus(grayTab[i], 1'b0, 1'b1, 8'(i + 1), 8'h01, 1'b0);
        end

        // Walk back to zero, jump to 255/254, then wrap 254 -> 255 -> 0.
        applyStimulus(8'h0C, 1'b0, 1'b1, 8'h08, 8'hFF, 1'b0);
        applyStimulus(8'h04, 1'b0, 1'b1, 8'h07, 8'hFF, 1'b0);
        applyStimulus(8'h00, 1'b0, 1'b1, 8'h00, 8'hF9, 1'b0);
        applyStimulus(8'h80, 1'b0, 1'b1, 8'hFF, 8'hFF, 1'b0);
        applyStimulus(8'h81, 1'b0, 1'b1, 8'hFE, 8'hFF, 1'b0);
        applyStimulus(8'h80, 1'b0, 1'b1, 8'hFF, 8'h01, 1'b0);
        applyStimulus(8'h00, 1'b0, 1'b1, 8'h00, 8'h01, 1'b0);
        idle(2);

        // Illegal two-bit jumps, then enough more to saturate the error counter.
        applyStimulus(8'h03, 1'b0, 1'b1, 8'h02, 8'h02, 1'b1);
        applyStimulus(8'h00, 1'b0, 1'b1, 8'h00, 8'hFE, 1'b1);
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) applyStimulus(8'h03, 1'b0, 1'b1, 8'h02, 8'h02, 1'b1);
            else            applyStimulus(8'h00, 1'b0, 1'b1, 8'h00, 8'hFE, 1'b1);
        end

        // Clear coinciding with a new error, then clear alone.
        applyStimulus(8'h03, 1'b1, 1'b1, 8'h02, 8'h02, 1'b1);
        applyStimulus(8'h03, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
        idle(3);
        checkOutput("clr_errcnt", 32'(err_cnt), 32'h0);

        // Move to 0x40, then reset asynchronously mid-cycle.
        applyStimulus(8'h60, 1'b0, 1'b1, 8'h40, 8'h3E, 1'b1);
        idle(4);
        checkOutput("pre_rst_addr",   32'(addr),    32'h40);
        checkOutput("pre_rst_errcnt", 32'(err_cnt), 32'(expErrCnt));
        @(posedge sys_clk);
        #2;
        sys_rst_n = 1'b0;
        #1;
        checkOutput("async_rst_addr",    32'(addr),     32'h0);
        checkOutput("async_rst_vld",     32'(addr_vld), 32'h0);
        checkOutput("async_rst_delta",   32'(delta),    32'h0);
        checkOutput("async_rst_steperr", 32'(step_err), 32'h0);
        checkOutput("async_rst_errcnt",  32'(err_cnt),  32'h0);
        expErrCnt = 4'd0;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge sys_clk);
            checkOutput("reprime_addr", 32'(addr), (i == 2) ? 32'h40 : 32'h00);
        end
        idle(3);

        checkOutput("sb_drained", 32'(sbQ.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/gray2bin_sync.md
Name: gray2bin_sync

Overview:
- Parametrised successor to the registered Gray-to-binary converter.
- Samples a Gray-coded pointer or address arriving from another clock domain through a configurable synchroniser chain, then converts it to binary and registers it.
- Also reports when the value has changed, the binary step size, and illegal multi-bit Gray transitions.
- Sits on the read/write-pointer crossing path of async FIFOs and similar address-sharing logic.

Parameters:
- WIDTH, 8, width of Gray input and binary output.
- SYNC_STAGES, 2, number of synchroniser flops on addr_gray (legal 2..4).
- ERR_CNT_W, 4, width of the saturating step-error counter.

Ports:
- sys_clk  input  1  system clock, all flops rising edge.
- sys_rst_n  input  1  system reset, asynchronous, active-low.
- addr_gray  input  WIDTH  Gray pointer from the foreign domain; unqualified, changes asynchronously.
- err_clr  input  1  synchronous clear of err_cnt.
- addr  output  WIDTH  registered binary value of the synchronised Gray input.
- addr_vld  output  1  one-cycle pulse: addr changed on this edge.
- delta  output  WIDTH  (new addr − previous addr) mod 2^WIDTH; valid while addr_vld=1, otherwise 0.
- step_err  output  1  one-cycle pulse: the synchronised Gray word changed by more than one bit.
- err_cnt  output  ERR_CNT_W  saturating count of step_err pulses.

Behaviour:
- Reset (asynchronous, any time including mid-operation):
  - Sync chain, prev_gray, addr, delta and err_cnt clear to 0.
  - addr_vld and step_err clear to 0.
  - primed clears to 0.
  - Fill counter clears to 0.
- Sync chain:
  - s[0] <= addr_gray; s[k] <= s[k-1].
  - s_last = s[SYNC_STAGES-1].
  - No logic between sync flops.
- Conversion:
  - bin(s_last)[i] = XOR of s_last[WIDTH-1:i].
  - Combinational from s_last; registered into addr every cycle.
  - Latency from a stable addr_gray to addr is SYNC_STAGES+1 edges.
  - prev_gray <= s_last every cycle, tracking the Gray word that produced addr.
- Priming:
  - Fill counter increments each edge after reset release, up to SYNC_STAGES+1.
  - primed = 1 once the counter reaches SYNC_STAGES+1, i.e. after the first valid value has been loaded into addr.
  - While primed=0: addr still loads normally, but addr_vld, delta and step_err are forced to 0. The first post-reset load never pulses.
- Change detect, evaluated when primed=1 at the edge:
  - addr_vld <= (s_last != prev_gray).
  - delta <= bin(s_last) − addr, truncated to WIDTH bits; 0 when there is no change.
  - Wrap from 2^WIDTH−1 to 0 yields delta=1.
- Step check, evaluated when primed=1:
  - step_err <= popcount(s_last ^ prev_gray) > 1.
  - addr still updates to the new value on an illegal step; it is not held.
- err_cnt:
  - Increments on each step_err pulse; saturates at 2^ERR_CNT_W−1.
  - err_clr has priority over increment. If err_clr and a new step error land on the same edge, err_cnt <= 1 (clear, then count the new error).
- No backpressure: the block is free-running. One sample is taken per cycle.

Optional Feature:
- Macro GRAY_STEP_CHK_EN.
- Defined: popcount comparator, step_err and err_cnt logic are implemented as described above.
- Undefined: no checker or counter logic is compiled; step_err and err_cnt are tied to 0 and err_clr is ignored. addr, addr_vld and delta are unaffected.

Test Plan:
1. Reset release with addr_gray held at 0x0C (WIDTH=8, SYNC_STAGES=2) -> addr=0 during reset, addr=0x08 on the 3rd edge after release; addr_vld, step_err and delta stay 0 throughout.
2. Drive Gray codes of 0..9, one per cycle -> addr follows 0..9 three edges later; addr_vld=1 and delta=1 on each change; step_err=0; err_cnt=0.
3. Wrap: drive 0x81, then 0x80, then 0x00 (binary 254, 255, 0) -> addr 254, 255, 0; delta=1 at both steps; no step_err.
4. Illegal jump 0x00 -> 0x03 -> addr=0x02, delta=2, addr_vld=1, step_err pulses one cycle, err_cnt=1. With the macro undefined: step_err=0, err_cnt=0.
5. Saturation and clear (ERR_CNT_W=4): apply 20 illegal jumps -> err_cnt=15. Then assert err_clr on the same edge as a new illegal jump -> err_cnt=1. Then err_clr alone -> err_cnt=0.
6. Assert sys_rst_n low asynchronously mid-stream while addr=0x40 -> all outputs read 0 immediately. After release with stable input 0x60 (Gray of 0x40): addr=0x40 on the 3rd edge, with no addr_vld pulse.
